// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce bank: channel FSM state
// encodings, the reset value of the shared timeout, and a helper that sizes
// the readback select port.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE  = 2'd0,
    BOUNCE1 = 2'd1,
    BOUNCE2 = 2'd2
  } dstate_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lstate_e;

  localparam int unsigned DEFAULT_TIMEOUT = 50000;

  // Width of a channel select; never narrower than one bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Bus bundle for debounce_bank. The master modport is the host side that
// drives the raw inputs and control strobes; the slave modport is the bank.
interface debounce_bank_if
  import debounce_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int POS_W = 32,
  parameter int TMR_W = 32
);
  localparam int SEL_W = sel_width(N_CH);

  logic [N_CH-1:0]  sig_in;
  logic [POS_W-1:0] pos_in;
  logic [TMR_W-1:0] data_in;
  logic             set_timeout;
  logic [N_CH-1:0]  unlock;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  sig_out;
  logic [N_CH-1:0]  sig_changed;
  logic             any_changed;
  logic [POS_W-1:0] pos_out;
  logic [7:0]       cycles;
  logic [TMR_W-1:0] max_bounce;

  modport master (
    output sig_in, pos_in, data_in, set_timeout, unlock, sel,
    input  sig_out, sig_changed, any_changed, pos_out, cycles, max_bounce
  );

  modport slave (
    input  sig_in, pos_in, data_in, set_timeout, unlock, sel,
    output sig_out, sig_changed, any_changed, pos_out, cycles, max_bounce
  );
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, bounce FSM (STABLE/BOUNCE1/
// BOUNCE2) with a saturating phase timer, and the UNLOCKED/LOCKED capture FSM.
// The timer counts samples already seen in the current phase; timer+1 is the
// phase length including the current sample and is what gets compared against
// the timeout and recorded as a bounce length.
// Optional feature: define DEBOUNCE_BANK_MAXB_EN to keep a per-channel
// longest-bounce register; otherwise max_bounce is tied to zero.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int POS_W = 32,
  parameter int TMR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic [POS_W-1:0] pos_in,
  input  logic [TMR_W-1:0] timeout,
  input  logic             unlock,
  output logic             sig_out,
  output logic             sig_changed,
  output logic [POS_W-1:0] pos_out,
  output logic [7:0]       cycles,
  output logic [TMR_W-1:0] max_bounce
);

  logic [1:0]       sync_q, sync_d;
  dstate_e          dstate_q, dstate_d;
  logic             value_q, value_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0] start_pos_q, start_pos_d;
  lstate_e          lstate_q, lstate_d;
  logic             sig_out_q, sig_out_d;
  logic             sig_changed_q, sig_changed_d;
  logic [POS_W-1:0] pos_out_q, pos_out_d;
  logic [7:0]       cycles_q, cycles_d;

  logic             sync;
  logic [TMR_W-1:0] timer_inc;
  logic             value_changed;

  assign sync      = sync_q[1];
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  // Next state for the synchroniser, bounce FSM and capture FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    sync_d        = {sync_q[0], sig_in};
    dstate_d      = dstate_q;
    value_d       = value_q;
    timer_d       = timer_q;
    start_pos_d   = start_pos_q;
    value_changed = 1'b0;

    unique case (dstate_q)
      STABLE: begin
        if (sync != value_q) begin
          dstate_d    = BOUNCE1;
          timer_d     = '0;
          start_pos_d = pos_in;
        end
      end
      BOUNCE1: begin
        if (sync != value_q) begin
          timer_d = timer_inc;
          if (timer_inc > timeout) begin
            value_d       = sync;
            value_changed = 1'b1;
            dstate_d      = STABLE;
          end
        end else begin
          dstate_d = BOUNCE2;
          timer_d  = '0;
        end
      end
      BOUNCE2: begin
        if (sync == value_q) begin
          timer_d = timer_inc;
          if (timer_inc > timeout) dstate_d = STABLE;
        end else begin
          dstate_d = BOUNCE1;
          timer_d  = '0;
        end
      end
      default: dstate_d = STABLE;
    endcase

    lstate_d      = lstate_q;
    sig_out_d     = sig_out_q;
    sig_changed_d = sig_changed_q;
    pos_out_d     = pos_out_q;
    // Every committed transition is counted, locked or not.
    cycles_d      = value_changed ? cycles_q + 8'd1 : cycles_q;

    unique case (lstate_q)
      UNLOCKED: begin
        // An unlock in the same cycle swallows the event: counted only.
        if (value_changed && !unlock) begin
          lstate_d      = LOCKED;
          sig_changed_d = 1'b1;
          sig_out_d     = value_d;
          pos_out_d     = start_pos_q;
        end
      end
      LOCKED: begin
        if (unlock) begin
          lstate_d      = UNLOCKED;
          sig_changed_d = 1'b0;
          sig_out_d     = value_d;
        end
      end
      default: lstate_d = UNLOCKED;
    endcase
  end

  // Channel state registers; reset aborts any bounce in progress.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      sync_q        <= '0;
      dstate_q      <= STABLE;
      value_q       <= 1'b0;
      timer_q       <= '0;
      start_pos_q   <= '0;
      lstate_q      <= UNLOCKED;
      sig_out_q     <= 1'b0;
      sig_changed_q <= 1'b0;
      pos_out_q     <= '0;
      cycles_q      <= '0;
    end else begin
      sync_q        <= sync_d;
      dstate_q      <= dstate_d;
      value_q       <= value_d;
      timer_q       <= timer_d;
      start_pos_q   <= start_pos_d;
      lstate_q      <= lstate_d;
      sig_out_q     <= sig_out_d;
      sig_changed_q <= sig_changed_d;
      pos_out_q     <= pos_out_d;
      cycles_q      <= cycles_d;
    end
  end

  assign sig_out     = sig_out_q;
  assign sig_changed = sig_changed_q;
  assign pos_out     = pos_out_q;
  assign cycles      = cycles_q;

`ifdef DEBOUNCE_BANK_MAXB_EN
  logic [TMR_W-1:0] max_bounce_q, max_bounce_d;
  logic             bounce_exit;

  assign bounce_exit = ((dstate_q == BOUNCE1) && (sync == value_q)) ||
                       ((dstate_q == BOUNCE2) && (sync != value_q));

  // Track the longest BOUNCE1<->BOUNCE2 phase; unlock restarts the record.
  always_comb begin
    max_bounce_d = max_bounce_q;
    if (unlock) max_bounce_d = '0;
    else if (bounce_exit && (timer_inc > max_bounce_q)) max_bounce_d = timer_inc;
  end

  // Longest-bounce register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) max_bounce_q <= '0;
    else       max_bounce_q <= max_bounce_d;
  end

  assign max_bounce = max_bounce_q;
`else
  assign max_bounce = '0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounce channels sharing one programmable
// timeout, with a combinational readback mux for the selected channel.
// Optional feature: DEBOUNCE_BANK_MAXB_EN enables per-channel max_bounce.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int POS_W = 32,
  parameter int TMR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  debounce_bank_if.slave   bus
);

  logic [TMR_W-1:0] timeout_q, timeout_d;
  logic [N_CH-1:0]  sig_out_w;
  logic [N_CH-1:0]  sig_changed_w;
  logic [POS_W-1:0] pos_arr [N_CH];
  logic [7:0]       cyc_arr [N_CH];
  logic [TMR_W-1:0] mb_arr  [N_CH];

  // Shared timeout load; takes effect on every channel from the next cycle.
  always_comb begin
    timeout_d = bus.set_timeout ? bus.data_in : timeout_q;
  end

  // Shared timeout register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timeout_q <= TMR_W'(DEFAULT_TIMEOUT);
    else       timeout_q <= timeout_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .POS_W (POS_W),
      .TMR_W (TMR_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .sig_in      (bus.sig_in[i]),
      .pos_in      (bus.pos_in),
      .timeout     (timeout_q),
      .unlock      (bus.unlock[i]),
      .sig_out     (sig_out_w[i]),
      .sig_changed (sig_changed_w[i]),
      .pos_out     (pos_arr[i]),
      .cycles      (cyc_arr[i]),
      .max_bounce  (mb_arr[i])
    );
  end

  assign bus.sig_out     = sig_out_w;
  assign bus.sig_changed = sig_changed_w;
  assign bus.any_changed = |sig_changed_w;

  // Readback of the selected channel; out-of-range selects read zero.
  always_comb begin
    bus.pos_out    = '0;
    bus.cycles     = '0;
    bus.max_bounce = '0;
    if (int'(bus.sel) < N_CH) begin
      bus.pos_out    = pos_arr[bus.sel];
      bus.cycles     = cyc_arr[bus.sel];
      bus.max_bounce = mb_arr[bus.sel];
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank. Expected channel states are queued
// when stimulus is applied and compared when the channel commits.
module tb_debounce_bank;
  import debounce_pkg::*;

  localparam int N_CH  = 4;
  localparam int POS_W = 32;
  localparam int TMR_W = 32;
  localparam int SEL_W = sel_width(N_CH);
  localparam int LAT   = 14;  // input edge -> lock with timeout 10
`ifdef DEBOUNCE_BANK_MAXB_EN
  localparam logic [31:0] EXP_MAXB = 32'd4;
`else
  localparam logic [31:0] EXP_MAXB = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debounce_bank_if #(.N_CH(N_CH), .POS_W(POS_W), .TMR_W(TMR_W)) bus ();

  debounce_bank #(.N_CH(N_CH), .POS_W(POS_W), .TMR_W(TMR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    int          ch;
    logic        sig_out;
    logic        sig_changed;
    logic [31:0] pos;
    logic [7:0]  cyc;
    logic [31:0] maxb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int ch, input logic so, input logic sc,
                          input logic [31:0] pos, input logic [7:0] cyc, input logic [31:0] mb);
    exp_t e;
    e.tag = tag; e.ch = ch; e.sig_out = so; e.sig_changed = sc;
    e.pos = pos; e.cyc = cyc; e.maxb = mb;
    sb_q.push_back(e);
  endtask

  task automatic pop_and_compare();
    exp_t e;
    check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    bus.sel = SEL_W'(e.ch);
    #1;
    check({e.tag, "_sig_out"},     32'(bus.sig_out[e.ch]),     32'(e.sig_out));
    check({e.tag, "_sig_changed"}, 32'(bus.sig_changed[e.ch]), 32'(e.sig_changed));
    check({e.tag, "_pos_out"},     bus.pos_out,                e.pos);
    check({e.tag, "_cycles"},      32'(bus.cycles),            32'(e.cyc));
    check({e.tag, "_max_bounce"},  bus.max_bounce,             e.maxb);
  endtask

  // Counts rising edges until channel ch's transition counter reaches target.
  task automatic wait_commit(input int ch, input logic [7:0] target, input int max_cyc,
                             output int cnt);
    cnt = 0;
    bus.sel = SEL_W'(ch);
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (bus.cycles !== target && cnt < max_cyc);
  endtask

  task automatic unlock_ch(input int ch);
    @(negedge clk);
    bus.unlock[ch] = 1'b1;
    @(negedge clk);
    bus.unlock[ch] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.sig_in      = '0;
    bus.pos_in      = '0;
    bus.data_in     = '0;
    bus.set_timeout = 1'b0;
    bus.unlock      = '0;
    bus.sel         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_sig_changed", 32'(bus.sig_changed), 32'd0);
    check("rst_sig_out",     32'(bus.sig_out),     32'd0);
    check("rst_any",         32'(bus.any_changed), 32'd0);
    push_exp("rst_ch0", 0, 1'b0, 1'b0, 32'h0, 8'd0, 32'd0);
    pop_and_compare();

    // Program timeout = 10.
    @(negedge clk);
    bus.data_in     = 32'd10;
    bus.set_timeout = 1'b1;
    @(negedge clk);
    bus.set_timeout = 1'b0;

    // Clean rise on ch0.
    @(negedge clk);
    bus.pos_in    = 32'h100;
    bus.sig_in[0] = 1'b1;
    push_exp("t1", 0, 1'b1, 1'b1, 32'h100, 8'd1, 32'd0);
    wait_commit(0, 8'd1, 40, n);
    check("t1_latency", 32'(n), 32'(LAT));
    pop_and_compare();
    check("t1_any", 32'(bus.any_changed), 32'd1);

    // Bouncy rise on ch1: three toggles with 4-cycle pulses, then high.
    @(negedge clk);
    bus.pos_in    = 32'h200;
    bus.sig_in[1] = 1'b1;
    push_exp("t2", 1, 1'b1, 1'b1, 32'h200, 8'd1, EXP_MAXB);
    repeat (4) @(negedge clk);
    bus.pos_in    = 32'h211;
    bus.sig_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    bus.pos_in    = 32'h222;
    bus.sig_in[1] = 1'b1;
    wait_commit(1, 8'd1, 40, n);
    check("t2_latency", 32'(n), 32'(LAT));
    pop_and_compare();

    // ch2: lock, then fall while locked (held), then unlock.
    @(negedge clk);
    bus.pos_in    = 32'h300;
    bus.sig_in[2] = 1'b1;
    push_exp("t3_lock", 2, 1'b1, 1'b1, 32'h300, 8'd1, 32'd0);
    wait_commit(2, 8'd1, 40, n);
    check("t3_lock_latency", 32'(n), 32'(LAT));
    pop_and_compare();
    @(negedge clk);
    bus.pos_in    = 32'h333;
    bus.sig_in[2] = 1'b0;
    push_exp("t3_fall", 2, 1'b1, 1'b1, 32'h300, 8'd2, 32'd0);
    wait_commit(2, 8'd2, 40, n);
    check("t3_fall_latency", 32'(n), 32'(LAT));
    pop_and_compare();
    unlock_ch(2);
    push_exp("t3_unlock", 2, 1'b0, 1'b0, 32'h300, 8'd2, 32'd0);
    pop_and_compare();

    // Re-arm ch0, then simultaneous edges on ch0 (fall) and ch3 (rise).
    unlock_ch(0);
    push_exp("t4_unlock0", 0, 1'b1, 1'b0, 32'h100, 8'd1, 32'd0);
    pop_and_compare();
    @(negedge clk);
    bus.pos_in    = 32'h400;
    bus.sig_in[0] = 1'b0;
    bus.sig_in[3] = 1'b1;
    push_exp("t4_ch0", 0, 1'b0, 1'b1, 32'h400, 8'd2, 32'd0);
    push_exp("t4_ch3", 3, 1'b1, 1'b1, 32'h400, 8'd1, 32'd0);
    wait_commit(3, 8'd1, 40, n);
    check("t4_latency", 32'(n), 32'(LAT));
    pop_and_compare();
    pop_and_compare();
    check("t4_any", 32'(bus.any_changed), 32'd1);

    // ch3: unlock lands on the same edge as a commit -> counted, not latched.
    @(negedge clk);
    bus.pos_in    = 32'h500;
    bus.sig_in[3] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    bus.unlock[3] = 1'b1;
    @(negedge clk);
    bus.unlock[3] = 1'b0;
    push_exp("t5_race", 3, 1'b0, 1'b0, 32'h400, 8'd2, 32'd0);
    pop_and_compare();
    // Channel must be UNLOCKED: the next edge locks with a fresh position.
    @(negedge clk);
    bus.pos_in    = 32'h600;
    bus.sig_in[3] = 1'b1;
    push_exp("t5_relock", 3, 1'b1, 1'b1, 32'h600, 8'd3, 32'd0);
    wait_commit(3, 8'd3, 40, n);
    check("t5_relock_latency", 32'(n), 32'(LAT));
    pop_and_compare();

    // Asynchronous reset in the middle of a ch0 BOUNCE1 phase.
    @(negedge clk);
    bus.sig_in[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_sig_changed", 32'(bus.sig_changed), 32'd0);
    check("t6_sig_out",     32'(bus.sig_out),     32'd0);
    check("t6_any",         32'(bus.any_changed), 32'd0);
    for (int c = 0; c < N_CH; c++) push_exp($sformatf("t6_rst_ch%0d", c), c, 1'b0, 1'b0, 32'h0, 8'd0, 32'd0);
    for (int c = 0; c < N_CH; c++) pop_and_compare();
    bus.pos_in = 32'h700;
    @(negedge clk);
    reset = 1'b0;
    // Timeout is back to 50000: lock T+4 edges after release.
    push_exp("t6_commit", 0, 1'b1, 1'b1, 32'h700, 8'd1, 32'd0);
    wait_commit(0, 8'd1, int'(DEFAULT_TIMEOUT) + 100, n);
    check("t6_latency", 32'(n), DEFAULT_TIMEOUT + 32'd4);
    pop_and_compare();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
